cia_irq_ctrl: RTL and testbench

Parametrised successor to the CIA interrupt control register (ICR) logic. It latches up to seven interrupt source flags and holds a set/clear mask written through the ICR address. It drives the open-drain-style `irq_n` output and a registered vector of the highest-priority pending source. Added over the fixed 5-source block: configurable source count, per-source edge/level detection, configurable source delay, and selectable set-vs-clear precedence on read-clear collisions.

---
 rtl/cia_irq_ctrl.sv | 135 +++++++++++++
 tb/tb_cia_irq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cia_irq_ctrl.sv
// CIA-style interrupt control register: latches source flags, holds a set/clear
// mask, drives irq_n and a registered vector of the highest-priority pending source.
module cia_irq_ctrl #(
  parameter int              NSRC      = 5,
  parameter logic [3:0]      ICR_ADDR  = 4'hD,
  parameter int              SRC_DELAY = 0,
  parameter logic [NSRC-1:0] EDGE_MASK = '0,
  parameter bit              SET_PRIO  = 1'b1
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            phi2_dn,
  input  logic            rd,
  input  logic            we,
  input  logic [3:0]      addr,
  input  logic [7:0]      data,
  input  logic [NSRC-1:0] sources,
  output logic [7:0]      regs,
  output logic            irq_n,
  output logic [2:0]      irq_vec
);

  logic [1:0]      ph;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] flags;
  logic [NSRC-1:0] smp;
  logic [NSRC-1:0] s;
  logic [NSRC-1:0] s_prev;
  logic [NSRC-1:0] set;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] flags_next;
  logic [2:0]      vec_next;
  logic [6:0]      flags_ext;
  logic            rd_flags;
  logic            irq;
  logic            icr_sel;
  logic            unused_data;

  assign icr_sel     = (addr == ICR_ADDR);
  assign unused_data = ^data[6:0];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ph <= 2'd0;
    end else if (phi2_dn) begin
      ph <= 2'd1;
    end else if (ph == 2'd1) begin
      ph <= 2'd2;
    end else begin
      ph <= 2'd0;
    end
  end

  // Bus-side state and the phi2 sample of the raw sources.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      mask     <= '0;
      rd_flags <= 1'b0;
      smp      <= '0;
      s_prev   <= '0;
    end else if (phi2_dn) begin
      if (we && icr_sel) begin
        mask <= data[7] ? (mask | data[NSRC-1:0]) : (mask & ~data[NSRC-1:0]);
      end
      rd_flags <= rd && icr_sel;
      smp      <= sources;
      s_prev   <= s;
    end
  end

  generate
    if (SRC_DELAY == 0) begin : g_nodly
      assign s = smp;
    end else begin : g_dly
      logic [NSRC-1:0] pipe [SRC_DELAY];
      always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
          for (int i = 0; i < SRC_DELAY; i++) pipe[i] <= '0;
        end else if (phi2_dn) begin
          pipe[0] <= smp;
          for (int i = 1; i < SRC_DELAY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign s = pipe[SRC_DELAY-1];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_set
      assign set[gi] = EDGE_MASK[gi] ? (s[gi] & ~s_prev[gi]) : s[gi];
    end
  endgenerate

  // A read-clear colliding with a set keeps the flag only when SET_PRIO is 1.
  always_comb begin
    flags_next = flags | set;
    if (rd_flags) flags_next = SET_PRIO ? set : '0;
  end

  assign pend = flags & mask;

  always_comb begin
    vec_next = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend[i]) vec_next = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      flags   <= '0;
      irq     <= 1'b0;
      irq_vec <= 3'd0;
    end else begin
      if (ph == 2'd1) flags <= flags_next;
      if (ph == 2'd2) begin
        if (rd_flags) begin
          irq <= 1'b0;
        end else if (|pend) begin
          irq     <= 1'b1;
          irq_vec <= vec_next;
        end
      end
    end
  end

  always_comb begin
    flags_ext             = '0;
    flags_ext[NSRC-1:0]   = flags;
  end

  assign regs  = {irq, flags_ext};
  assign irq_n = ~irq;

endmodule

// File: tb/tb_cia_irq_ctrl.sv
// Bench for cia_irq_ctrl: default, read-clear-wins, and delayed edge-source variants
// share one bus; a vector table plus hand-written multi-cycle sequences.
module tb_cia_irq_ctrl;

  localparam logic [3:0] A = 4'hD;

  logic       clk = 1'b0;
  logic       res_n;
  logic       phi2_dn;
  logic       rd;
  logic       we;
  logic [3:0] addr;
  logic [7:0] data;
  logic [4:0] sources;

  logic [7:0] regs_a, regs_b, regs_c;
  logic       irq_n_a, irq_n_b, irq_n_c;
  logic [2:0] vec_a, vec_b, vec_c;

  logic [7:0] ra [3];
  logic [7:0] rb [3];
  logic [7:0] rc [3];
  logic       na [3];
  logic       nb [3];
  logic       nc [3];
  logic [2:0] va [3];
  logic [2:0] vc [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cia_irq_ctrl dut_a (
    .clk(clk), .res_n(res_n), .phi2_dn(phi2_dn), .rd(rd), .we(we), .addr(addr),
    .data(data), .sources(sources), .regs(regs_a), .irq_n(irq_n_a), .irq_vec(vec_a)
  );

  cia_irq_ctrl #(.SET_PRIO(1'b0)) dut_b (
    .clk(clk), .res_n(res_n), .phi2_dn(phi2_dn), .rd(rd), .we(we), .addr(addr),
    .data(data), .sources(sources), .regs(regs_b), .irq_n(irq_n_b), .irq_vec(vec_b)
  );

  cia_irq_ctrl #(.SRC_DELAY(2), .EDGE_MASK(5'b00100)) dut_c (
    .clk(clk), .res_n(res_n), .phi2_dn(phi2_dn), .rd(rd), .we(we), .addr(addr),
    .data(data), .sources(sources), .regs(regs_c), .irq_n(irq_n_c), .irq_vec(vec_c)
  );

  typedef struct packed {
    logic       rd;
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic [4:0] src;
    logic [7:0] regs;
    logic       irq_n;
    logic [2:0] vec;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end else begin
      $display("ok   %s: %02h", nm, act);
    end
  endtask

  task automatic snap(input int k);
    ra[k] = regs_a; rb[k] = regs_b; rc[k] = regs_c;
    na[k] = irq_n_a; nb[k] = irq_n_b; nc[k] = irq_n_c;
    va[k] = vec_a; vc[k] = vec_c;
  endtask

  // One phi2 period of three clk; snapshots taken after the phi2_dn, ph1 and ph2 edges.
  task automatic phi(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d,
                     input logic [4:0] src, input bit pulse);
    rd = r; we = w; addr = a; data = d; sources = src; phi2_dn = 1'b1;
    @(negedge clk);
    phi2_dn = 1'b0; rd = 1'b0; we = 1'b0;
    if (pulse) sources = '0;
    snap(0);
    @(negedge clk);
    snap(1);
    @(negedge clk);
    snap(2);
  endtask

  task automatic do_reset();
    res_n = 1'b0; phi2_dn = 1'b0; rd = 1'b0; we = 1'b0;
    addr = A; data = 8'h00; sources = '0;
    repeat (2) @(negedge clk);
    res_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //           rd    we    addr  data   src       regs   irq_n vec
    tbl[0]  = '{1'b0, 1'b0, A,    8'h00, 5'h00,    8'h00, 1'b1, 3'd0};
    tbl[1]  = '{1'b0, 1'b1, A,    8'h81, 5'h00,    8'h00, 1'b1, 3'd0};
    tbl[2]  = '{1'b0, 1'b0, A,    8'h00, 5'h01,    8'h81, 1'b0, 3'd0};
    tbl[3]  = '{1'b1, 1'b0, A,    8'h00, 5'h00,    8'h00, 1'b1, 3'd0};
    tbl[4]  = '{1'b0, 1'b0, A,    8'h00, 5'h08,    8'h08, 1'b1, 3'd0};
    tbl[5]  = '{1'b0, 1'b1, A,    8'h88, 5'h00,    8'h88, 1'b0, 3'd3};
    tbl[6]  = '{1'b0, 1'b0, A,    8'h00, 5'h02,    8'h8A, 1'b0, 3'd3};
    tbl[7]  = '{1'b0, 1'b1, A,    8'h8A, 5'h00,    8'h8A, 1'b0, 3'd1};
    tbl[8]  = '{1'b0, 1'b1, A,    8'h02, 5'h00,    8'h8A, 1'b0, 3'd3};
    tbl[9]  = '{1'b1, 1'b0, A,    8'h00, 5'h00,    8'h00, 1'b1, 3'd3};
    tbl[10] = '{1'b0, 1'b1, A,    8'h01, 5'h00,    8'h00, 1'b1, 3'd3};
    tbl[11] = '{1'b0, 1'b0, A,    8'h00, 5'h01,    8'h01, 1'b1, 3'd3};
    tbl[12] = '{1'b0, 1'b1, 4'hC, 8'h81, 5'h00,    8'h01, 1'b1, 3'd3};
    tbl[13] = '{1'b0, 1'b1, A,    8'h81, 5'h00,    8'h81, 1'b0, 3'd0};
    tbl[14] = '{1'b0, 1'b1, A,    8'h01, 5'h00,    8'h81, 1'b0, 3'd0};
    tbl[15] = '{1'b1, 1'b0, A,    8'h00, 5'h00,    8'h00, 1'b1, 3'd0};
    tbl[16] = '{1'b0, 1'b1, A,    8'h90, 5'h10,    8'h90, 1'b0, 3'd4};
    tbl[17] = '{1'b1, 1'b0, A,    8'h00, 5'h10,    8'h10, 1'b1, 3'd4};
    tbl[18] = '{1'b0, 1'b0, A,    8'h00, 5'h00,    8'h90, 1'b0, 3'd4};

    do_reset();
    #1;
    chk("reset regs", regs_a, 8'h00);
    chk("reset irq_n", {7'd0, irq_n_a}, 8'h01);
    chk("reset vec", {5'd0, vec_a}, 8'h00);
    chk("reset regs_c", regs_c, 8'h00);
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      phi(tbl[i].rd, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].src, 1'b0);
      chk($sformatf("v%0d regs", i), ra[2], tbl[i].regs);
      chk($sformatf("v%0d irq_n", i), {7'd0, na[2]}, {7'd0, tbl[i].irq_n});
      chk($sformatf("v%0d vec", i), {5'd0, va[2]}, {5'd0, tbl[i].vec});
    end

    // Latency of a one-clk source pulse, then a read clearing it.
    do_reset();
    @(negedge clk);
    phi(1'b0, 1'b1, A, 8'h81, 5'h00, 1'b0);
    phi(1'b0, 1'b0, A, 8'h00, 5'h01, 1'b1);
    chk("lat e0 regs", ra[0], 8'h00);
    chk("lat ph1 regs", ra[1], 8'h01);
    chk("lat ph1 irq_n", {7'd0, na[1]}, 8'h01);
    chk("lat ph2 regs", ra[2], 8'h81);
    chk("lat ph2 irq_n", {7'd0, na[2]}, 8'h00);
    chk("lat ph2 vec", {5'd0, va[2]}, 8'h00);
    phi(1'b1, 1'b0, A, 8'h00, 5'h00, 1'b0);
    chk("rd e0 regs", ra[0], 8'h81);
    chk("rd ph1 regs", ra[1], 8'h80);
    chk("rd ph1 irq_n", {7'd0, na[1]}, 8'h00);
    chk("rd ph2 regs", ra[2], 8'h00);
    chk("rd ph2 irq_n", {7'd0, na[2]}, 8'h01);
    phi(1'b0, 1'b0, A, 8'h00, 5'h00, 1'b0);
    chk("rd next regs", ra[2], 8'h00);

    // Read colliding with a source-1 set: survives only with SET_PRIO=1.
    do_reset();
    @(negedge clk);
    phi(1'b0, 1'b1, A, 8'h82, 5'h00, 1'b0);
    phi(1'b1, 1'b0, A, 8'h00, 5'h02, 1'b1);
    chk("coll sp1 regs", ra[2], 8'h02);
    chk("coll sp1 irq_n", {7'd0, na[2]}, 8'h01);
    chk("coll sp0 regs", rb[2], 8'h00);
    chk("coll sp0 irq_n", {7'd0, nb[2]}, 8'h01);
    phi(1'b0, 1'b0, A, 8'h00, 5'h00, 1'b0);
    chk("coll+1 sp1 regs", ra[2], 8'h82);
    chk("coll+1 sp1 irq_n", {7'd0, na[2]}, 8'h00);
    chk("coll+1 sp1 vec", {5'd0, va[2]}, 8'h01);
    chk("coll+1 sp0 regs", rb[2], 8'h00);
    chk("coll+1 sp0 irq_n", {7'd0, nb[2]}, 8'h01);

    // Delayed edge source 2 held high for four phi2 cycles.
    do_reset();
    @(negedge clk);
    phi(1'b0, 1'b1, A, 8'h84, 5'h00, 1'b0);
    phi(1'b0, 1'b0, A, 8'h00, 5'h04, 1'b0);
    chk("dly c1 regs", rc[2], 8'h00);
    phi(1'b0, 1'b0, A, 8'h00, 5'h04, 1'b0);
    chk("dly c2 regs", rc[2], 8'h00);
    phi(1'b0, 1'b0, A, 8'h00, 5'h04, 1'b0);
    chk("dly c3 ph1 regs", rc[1], 8'h04);
    chk("dly c3 regs", rc[2], 8'h84);
    chk("dly c3 irq_n", {7'd0, nc[2]}, 8'h00);
    chk("dly c3 vec", {5'd0, vc[2]}, 8'h02);
    phi(1'b1, 1'b0, A, 8'h00, 5'h04, 1'b0);
    chk("dly c4 e0 regs", rc[0], 8'h84);
    chk("dly c4 regs", rc[2], 8'h00);
    chk("dly c4 irq_n", {7'd0, nc[2]}, 8'h01);
    phi(1'b0, 1'b0, A, 8'h00, 5'h00, 1'b0);
    chk("dly c5 regs", rc[2], 8'h00);
    phi(1'b0, 1'b0, A, 8'h00, 5'h00, 1'b0);
    chk("dly c6 regs", rc[2], 8'h00);

    // Reset between ph1 and ph2 with a flag pending.
    do_reset();
    @(negedge clk);
    phi(1'b0, 1'b1, A, 8'h81, 5'h00, 1'b0);
    phi(1'b0, 1'b0, A, 8'h00, 5'h01, 1'b0);
    chk("mrst pre irq_n", {7'd0, na[2]}, 8'h00);
    phi2_dn = 1'b1; sources = 5'h01;
    @(negedge clk);
    phi2_dn = 1'b0;
    @(negedge clk);
    res_n = 1'b0;
    #1;
    chk("mrst irq_n", {7'd0, irq_n_a}, 8'h01);
    chk("mrst regs", regs_a, 8'h00);
    chk("mrst vec", {5'd0, vec_a}, 8'h00);
    @(negedge clk);
    res_n = 1'b1;
    phi(1'b0, 1'b0, A, 8'h00, 5'h01, 1'b0);
    chk("mrst+1 regs", ra[2], 8'h01);
    chk("mrst+1 irq_n", {7'd0, na[2]}, 8'h01);
    phi(1'b0, 1'b1, A, 8'h81, 5'h01, 1'b0);
    chk("mrst+2 regs", ra[2], 8'h81);
    chk("mrst+2 irq_n", {7'd0, na[2]}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
